// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART TX arbiter: byte width, FSM state codes,
// default requester count and the round-robin pointer width helper.
package uart_arb_pkg;

  localparam int DEF_D_BIT   = 7;
  localparam int DEF_NUM_REQ = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'b00;
  localparam state_t WAIT_DONE = 2'b01;
  localparam state_t LOCKED    = 2'b10;

  // A single requester still needs a 1-bit pointer so the vectors stay legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_PTR_W = ptr_width(DEF_NUM_REQ);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-TX handshake bundle for uart_tx_arbiter.
// slave = the arbiter itself, master = requesters plus the UART TX core.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int D_BIT   = DEF_D_BIT
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*(D_BIT+1)-1:0]   req_data;
  logic [NUM_REQ-1:0]             req_lock;
  logic [NUM_REQ-1:0]             req_ack;
  logic [NUM_REQ-1:0]             grant;
  logic                           busy;
  logic                           tx_done;
  logic                           tx_start;
  logic [D_BIT:0]                 tx_dato_in;
  logic                           err_timeout;

  modport master (
    output req_valid, req_data, req_lock, tx_done,
    input  req_ack, grant, busy, tx_start, tx_dato_in, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_lock, tx_done,
    output req_ack, grant, busy, tx_start, tx_dato_in, err_timeout
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first valid index at or after ptr,
// wrapping modulo NUM_REQ.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PTR_W-1:0]   idx,
  output logic               any_valid
);

  int pos_s;

  // Scan from farthest to nearest so the nearest valid index is written last.
  always_comb begin
    idx       = {PTR_W{1'b0}};
    any_valid = 1'b0;
    pos_s     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos_s = (int'(ptr) + k) % NUM_REQ;
      if (valid[pos_s]) begin
        idx       = PTR_W'(pos_s);
        any_valid = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
    if (any_valid) begin
      onehot = NUM_REQ'(1'b1) << idx;
    end else begin
      onehot = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among NUM_REQ byte sources, with
// frame locking. Optional tx_done watchdog is built when TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int D_BIT          = DEF_D_BIT,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam int BW    = D_BIT + 1;

  state_t               state_r, state_nxt_s;
  logic [PTR_W-1:0]     ptr_r, ptr_nxt_s;
  logic [PTR_W-1:0]     owner_r, owner_nxt_s;
  logic                 lock_r, lock_nxt_s;
  logic [NUM_REQ-1:0]   grant_r, grant_nxt_s;
  logic [NUM_REQ-1:0]   ack_r, ack_nxt_s;
  logic                 start_r, start_nxt_s;
  logic [D_BIT:0]       data_r, data_nxt_s;
  logic                 err_r, err_nxt_s;
  logic                 busy_r;

  logic [NUM_REQ-1:0]   pick_onehot_s;
  logic [PTR_W-1:0]     pick_idx_s;
  logic                 pick_any_s;
  logic [PTR_W-1:0]     acc_idx_s;
  logic [NUM_REQ-1:0]   acc_onehot_s;
  logic                 accept_s;
  logic                 done_ok_s;
  logic                 timeout_s;
  logic [PTR_W-1:0]     ptr_after_s;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .valid     (bus.req_valid),
    .ptr       (ptr_r),
    .onehot    (pick_onehot_s),
    .idx       (pick_idx_s),
    .any_valid (pick_any_s)
  );

  // tx_done in the tx_start cycle belongs to the previous byte, never this one.
  assign done_ok_s   = bus.tx_done & ~start_r;
  assign ptr_after_s = (owner_r == PTR_W'(NUM_REQ - 1)) ? PTR_W'(1'b0) : owner_r + PTR_W'(1'b1);

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

  assign timeout_s = (state_r == WAIT_DONE) && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog count: cleared on every accept, advances while waiting for tx_done.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (accept_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (state_r == WAIT_DONE) begin
      cnt_nxt_s = cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Watchdog count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Accept source: round-robin winner when idle, only the owner while locked.
  always_comb begin
    acc_idx_s    = pick_idx_s;
    acc_onehot_s = pick_onehot_s;
    accept_s     = 1'b0;
    if (state_r == LOCKED) begin
      acc_idx_s    = owner_r;
      acc_onehot_s = grant_r;
      accept_s     = bus.req_valid[owner_r];
    end else if (state_r == IDLE) begin
      accept_s     = pick_any_s;
    end else begin
      accept_s     = 1'b0;
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= {PTR_W{1'b0}};
      owner_r <= {PTR_W{1'b0}};
      lock_r  <= 1'b0;
      grant_r <= {NUM_REQ{1'b0}};
      ack_r   <= {NUM_REQ{1'b0}};
      start_r <= 1'b0;
      data_r  <= {BW{1'b0}};
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      owner_r <= owner_nxt_s;
      lock_r  <= lock_nxt_s;
      grant_r <= grant_nxt_s;
      ack_r   <= ack_nxt_s;
      start_r <= start_nxt_s;
      data_r  <= data_nxt_s;
      err_r   <= err_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = WAIT_DONE;
        else          state_nxt_s = IDLE;
      end
      WAIT_DONE: begin
        if (done_ok_s)      state_nxt_s = lock_r ? LOCKED : IDLE;
        else if (timeout_s) state_nxt_s = IDLE;
        else                state_nxt_s = WAIT_DONE;
      end
      LOCKED: begin
        if (accept_s) state_nxt_s = WAIT_DONE;
        else          state_nxt_s = LOCKED;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer, owner and lock.
  always_comb begin
    start_nxt_s = 1'b0;
    ack_nxt_s   = {NUM_REQ{1'b0}};
    grant_nxt_s = grant_r;
    owner_nxt_s = owner_r;
    lock_nxt_s  = lock_r;
    ptr_nxt_s   = ptr_r;
    data_nxt_s  = data_r;
    err_nxt_s   = err_r;
    case (state_r)
      IDLE, LOCKED: begin
        if (accept_s) begin
          start_nxt_s = 1'b1;
          ack_nxt_s   = acc_onehot_s;
          grant_nxt_s = acc_onehot_s;
          owner_nxt_s = acc_idx_s;
          lock_nxt_s  = bus.req_lock[acc_idx_s];
          data_nxt_s  = bus.req_data[int'(acc_idx_s) * BW +: BW];
        end else begin
          start_nxt_s = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (done_ok_s) begin
          if (!lock_r) begin
            grant_nxt_s = {NUM_REQ{1'b0}};
            ptr_nxt_s   = ptr_after_s;
          end else begin
            grant_nxt_s = grant_r;
          end
        end else if (timeout_s) begin
          err_nxt_s   = 1'b1;
          grant_nxt_s = {NUM_REQ{1'b0}};
          lock_nxt_s  = 1'b0;
          ptr_nxt_s   = ptr_after_s;
        end else begin
          grant_nxt_s = grant_r;
        end
      end
      default: begin
        grant_nxt_s = {NUM_REQ{1'b0}};
        lock_nxt_s  = 1'b0;
      end
    endcase
  end

  assign bus.req_ack     = ack_r;
  assign bus.grant       = grant_r;
  assign bus.busy        = busy_r;
  assign bus.tx_start    = start_r;
  assign bus.tx_dato_in  = data_r;
  assign bus.err_timeout = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed steps plus randomized
// frames checked against a queue-based arbitration model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 50;
  localparam int M_FREE = 0;
  localparam int M_WAIT = 1;
  localparam int M_LOCK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .D_BIT(7)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .D_BIT(7), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int mode, ptr_m, owner_m, cnt_done, exp_w;
  bit lock_m, exp_start, rnd_gaps, rnd_spur;
  logic [8:0] q [NR][$];
  logic [7:0] sent [$];
  logic [7:0] exp_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int w);
    logic [NR-1:0] one;
    one = 4'b0001;
    return one << w;
  endfunction

  task automatic load(input int r, input logic lk, input logic [7:0] d);
    q[r].push_back({lk, d});
  endtask

  task automatic model_reset();
    mode = M_FREE; ptr_m = 0; owner_m = 0; lock_m = 1'b0;
    exp_start = 1'b0; cnt_done = 0;
    for (int i = 0; i < NR; i++) q[i].delete();
  endtask

  // One clock of the requester/UART environment plus the arbitration model.
  task automatic step();
    logic [NR-1:0] vld;
    logic [8:0] head;
    bit done_drive;
    @(negedge clk);
    chk("tx_start", bus.tx_start, exp_start);
    if (exp_start) begin
      head = q[exp_w][0];
      chk("tx_dato_in", bus.tx_dato_in, head[7:0]);
      chk("req_ack", bus.req_ack, oh(exp_w));
      sent.push_back(head[7:0]);
      lock_m = head[8];
      void'(q[exp_w].pop_front());
      owner_m = exp_w;
      mode = M_WAIT;
      cnt_done = $urandom_range(1, 6);
    end else begin
      chk("req_ack_quiet", bus.req_ack, 0);
    end
    chk("grant", bus.grant, (mode == M_FREE) ? 4'b0000 : oh(owner_m));
    chk("busy", bus.busy, (mode != M_FREE) ? 1 : 0);
    done_drive = 1'b0;
    if (mode == M_WAIT && !exp_start) begin
      cnt_done--;
      done_drive = (cnt_done == 0);
    end
    bus.tx_done = done_drive | (rnd_spur && (exp_start || mode != M_WAIT) && ($urandom_range(0, 3) == 0));
    for (int i = 0; i < NR; i++) begin
      vld[i] = (q[i].size() != 0) && (!rnd_gaps || ($urandom_range(0, 3) != 0));
      if (q[i].size() != 0) begin
        head = q[i][0];
        bus.req_data[i*8 +: 8] = head[7:0];
        bus.req_lock[i] = head[8];
      end
    end
    bus.req_valid = vld;
    exp_start = 1'b0;
    if (mode == M_FREE) begin
      for (int k = 0; k < NR; k++) begin
        int w;
        w = (ptr_m + k) % NR;
        if (!exp_start && vld[w]) begin
          exp_start = 1'b1;
          exp_w = w;
        end
      end
    end else if (mode == M_LOCK && vld[owner_m]) begin
      exp_start = 1'b1;
      exp_w = owner_m;
    end
    if (done_drive) begin
      if (lock_m) mode = M_LOCK;
      else begin
        mode = M_FREE;
        ptr_m = (owner_m + 1) % NR;
      end
    end
  endtask

  function automatic bit all_idle();
    bit e;
    e = (mode == M_FREE) && !exp_start;
    for (int i = 0; i < NR; i++) e = e && (q[i].size() == 0);
    return e;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    chk(tag, all_idle(), 1);
    @(negedge clk);
    bus.tx_done = 1'b0;
    bus.req_valid = '0;
    chk({tag, "_grant_idle"}, bus.grant, 0);
    chk({tag, "_busy_idle"}, bus.busy, 0);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, sent.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < sent.size(); i++)
      chk(tag, sent[i], exp_log[i]);
    sent.delete();
    exp_log.delete();
  endtask

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.req_lock = '0; bus.tx_done = 1'b0;
    rnd_gaps = 1'b0; rnd_spur = 1'b0;
    model_reset();

    #12;
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_dato_in", bus.tx_dato_in, 0);
    chk("rst_req_ack", bus.req_ack, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_timeout, 0);

    // Single byte from requester 1, tx_done about 20 cycles later.
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'b0010;
    bus.req_data = 32'h0000_4100;
    @(negedge clk);
    chk("single_start", bus.tx_start, 1);
    chk("single_data", bus.tx_dato_in, 8'h41);
    chk("single_ack", bus.req_ack, 4'b0010);
    chk("single_grant", bus.grant, 4'b0010);
    chk("single_busy", bus.busy, 1);
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_start_pulse", bus.tx_start, 0);
    chk("single_ack_pulse", bus.req_ack, 0);
    repeat (18) @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk("single_grant_end", bus.grant, 0);
    chk("single_busy_end", bus.busy, 0);
    ptr_m = 2;

    // All four valid with the pointer at 2.
    for (int i = 0; i < NR; i++) load(i, 1'b0, 8'hA0 + 8'(i));
    drain("rr_p2", 200);
    exp_log = '{8'hA2, 8'hA3, 8'hA0, 8'hA1};
    chk_log("rr_p2_order");

    // Requester 3 alone moves the pointer to 0, then two full rounds.
    load(3, 1'b0, 8'h33);
    drain("p_to_0", 100);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) load(i, 1'b0, 8'hA0 + 8'(i));
    drain("rr_p0", 300);
    exp_log = '{8'h33, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    chk_log("rr_p0_order");

    // Locked frame from requester 0 while requester 3 waits.
    load(0, 1'b1, 8'hB0); load(0, 1'b1, 8'hB1); load(0, 1'b0, 8'hB2);
    load(3, 1'b0, 8'hC3);
    drain("lock", 300);
    exp_log = '{8'hB0, 8'hB1, 8'hB2, 8'hC3};
    chk_log("lock_order");

    // Spurious tx_done in IDLE, early tx_done in the tx_start cycle.
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk("spur_idle_busy", bus.busy, 0);
    chk("spur_idle_start", bus.tx_start, 0);
    bus.req_valid = 4'b0100;
    bus.req_lock = 4'b0000;
    bus.req_data = 32'h005A_0000;
    @(negedge clk);
    chk("early_start", bus.tx_start, 1);
    chk("early_grant", bus.grant, 4'b0100);
    bus.tx_done = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk("early_ignored_busy", bus.busy, 1);
    chk("early_ignored_grant", bus.grant, 4'b0100);
    repeat (3) @(negedge clk);
    chk("early_still_busy", bus.busy, 1);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk("late_done_busy", bus.busy, 0);
    chk("late_done_grant", bus.grant, 0);

    // Reset in the middle of a locked frame.
    bus.req_valid = 4'b0001;
    bus.req_lock = 4'b0001;
    bus.req_data = 32'h0000_00C0;
    @(negedge clk);
    chk("midrst_grant_before", bus.grant, 4'b0001);
    bus.req_valid = '0;
    bus.req_lock = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_grant", bus.grant, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_start", bus.tx_start, 0);
    chk("midrst_data", bus.tx_dato_in, 0);
    chk("midrst_ack", bus.req_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    load(2, 1'b0, 8'hD2);
    load(3, 1'b0, 8'hD3);
    drain("after_rst", 100);
    exp_log = '{8'hD2, 8'hD3};
    chk_log("after_rst_order");

`ifdef TX_ARB_TIMEOUT_EN
    // Watchdog: no tx_done for TO cycles.
    bus.req_valid = 4'b0010;
    bus.req_data = 32'h0000_7700;
    @(negedge clk);
    chk("to_start", bus.tx_start, 1);
    bus.req_valid = '0;
    repeat (TO - 1) @(negedge clk);
    chk("to_busy_before", bus.busy, 1);
    chk("to_err_before", bus.err_timeout, 0);
    @(negedge clk);
    chk("to_busy", bus.busy, 0);
    chk("to_err", bus.err_timeout, 1);
    chk("to_grant", bus.grant, 0);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk("to_late_done", bus.busy, 0);
    ptr_m = 2;
    load(3, 1'b0, 8'h88);
    drain("to_after", 100);
    exp_log = '{8'h88};
    chk_log("to_after_order");
    chk("to_err_sticky", bus.err_timeout, 1);
`endif

    // Randomized frames with valid gaps and spurious tx_done pulses.
    rnd_gaps = 1'b1;
    rnd_spur = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int r, len;
      r = $urandom_range(0, NR - 1);
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) load(r, (j < len - 1) ? 1'b1 : 1'b0, 8'($urandom));
    end
    drain("random", 20000);
    sent.delete();

`ifdef TX_ARB_TIMEOUT_EN
    chk("final_err", bus.err_timeout, 1);
`else
    chk("final_err", bus.err_timeout, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
